// File: rtl/adc_ltc2308_pkg.sv
// rtl/adc_ltc2308_pkg.sv - shared types, config constants and helpers for the LTC2308 scanner
package adc_ltc2308_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CONV,
      ST_SHIFT,
      ST_GAP,
      ST_HOLD
   } state_t;

   localparam logic CFG_SE  = 1'b1;
   localparam logic CFG_SLP = 1'b0;

   // LTC2308 single-ended addressing interleaves the channel bits as {odd, sel1, sel0}
   function automatic logic [5:0] cfg_word(input logic [2:0] ch, input logic uni);
      return {CFG_SE, ch[0], ch[2], ch[1], uni, CFG_SLP};
   endfunction

   function automatic logic [2:0] lowest_ch(input logic [7:0] mask);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (mask[i]) r = 3'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/adc_ltc2308_scan_if.sv
// rtl/adc_ltc2308_scan_if.sv - valid/ready sample port of the LTC2308 scanner
interface adc_ltc2308_scan_if;
   logic [11:0] sample_data;
   logic [2:0]  sample_ch;
   logic        sample_last;
   logic        sample_valid;
   logic        sample_ready;

   modport master (
      output sample_data, sample_ch, sample_last, sample_valid,
      input  sample_ready
   );

   modport slave (
      input  sample_data, sample_ch, sample_last, sample_valid,
      output sample_ready
   );
endinterface

// File: rtl/adc_ltc2308_frame.sv
// rtl/adc_ltc2308_frame.sv - one CONVST + 12-bit SPI exchange with the LTC2308
module adc_ltc2308_frame #(
   parameter int SCK_HALF  = 2,
   parameter int TCONV_CYC = 80,
   parameter int CONVST_W  = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        go,
   input  logic [5:0]  cfg,
   input  logic        sdo,
   output logic        convst,
   output logic        sck,
   output logic        sdi,
   output logic [11:0] result,
   output logic        conv_end,
   output logic        done
);
   localparam int CW = $clog2(TCONV_CYC + 2 * SCK_HALF);

   logic          conv_act;
   logic          shift_act;
   logic [CW-1:0] cnt;
   logic [3:0]    bit_idx;
   logic [5:0]    cfg_sr;
   logic [11:0]   shreg;

   assign conv_end = conv_act && (cnt == CW'(TCONV_CYC - 1));
   assign done     = shift_act && (bit_idx == 4'd11) && (cnt == CW'(2 * SCK_HALF - 1));
   assign result   = shreg;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         conv_act  <= 1'b0;
         shift_act <= 1'b0;
         cnt       <= '0;
         bit_idx   <= '0;
         cfg_sr    <= '0;
         shreg     <= '0;
         convst    <= 1'b0;
         sck       <= 1'b0;
         sdi       <= 1'b0;
      end else if (go) begin
         conv_act  <= 1'b1;
         shift_act <= 1'b0;
         cnt       <= '0;
         convst    <= 1'b1;
         sck       <= 1'b0;
         sdi       <= 1'b0;
      end else if (conv_act) begin
         if (cnt == CW'(CONVST_W - 1)) convst <= 1'b0;
         if (conv_end) begin
            conv_act  <= 1'b0;
            shift_act <= 1'b1;
            cnt       <= '0;
            bit_idx   <= '0;
            cfg_sr    <= {cfg[4:0], 1'b0};
            sdi       <= cfg[5];
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else if (shift_act) begin
         // sdo is taken on the same edge that raises sck; sdi only moves on the falling edge
         if (cnt == CW'(SCK_HALF - 1)) begin
            sck   <= 1'b1;
            shreg <= {shreg[10:0], sdo};
         end
         if (cnt == CW'(2 * SCK_HALF - 1)) begin
            cnt     <= '0;
            sck     <= 1'b0;
            bit_idx <= bit_idx + 4'd1;
            sdi     <= cfg_sr[5];
            cfg_sr  <= {cfg_sr[4:0], 1'b0};
            if (done) shift_act <= 1'b0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/adc_ltc2308_scan.sv
// rtl/adc_ltc2308_scan.sv - LTC2308 channel-mask scanner with sample register and sticky done irq
module adc_ltc2308_scan
   import adc_ltc2308_pkg::*;
#(
   parameter int SCK_HALF  = 2,
   parameter int TCONV_CYC = 80,
   parameter int CONVST_W  = 2,
   parameter int GAP_CYC   = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               continuous,
   input  logic [7:0]         ch_mask,
   input  logic               uni,
   adc_ltc2308_scan_if.master sample,
   output logic               scan_done_irq,
   input  logic               irq_clear,
   output logic               busy,
   output logic               adc_convst,
   output logic               adc_sck,
   output logic               adc_sdi,
   input  logic               adc_sdo
);
   localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   state_t        state, state_nx;
   logic          go, start_scan, conv_end, frame_end, gap_end, load;
   logic [GW-1:0] gap_cnt;
   logic [11:0]   result;
   logic          uni_q;
   logic [2:0]    first_ch, cfg_ch, conv_ch;
   logic [7:0]    cfg_left;
   logic          conv_valid, dummy, scan_over;

   adc_ltc2308_frame #(
      .SCK_HALF (SCK_HALF),
      .TCONV_CYC(TCONV_CYC),
      .CONVST_W (CONVST_W)
   ) u_frame (
      .clk     (clk),
      .reset_n (reset_n),
      .go      (go),
      .cfg     (cfg_word(cfg_ch, uni_q)),
      .sdo     (adc_sdo),
      .convst  (adc_convst),
      .sck     (adc_sck),
      .sdi     (adc_sdi),
      .result  (result),
      .conv_end(conv_end),
      .done    (frame_end)
   );

   assign busy    = (state != ST_IDLE);
   assign gap_end = (state == ST_GAP) && (gap_cnt == GW'(GAP_CYC - 1));
   assign load    = frame_end && conv_valid;

   always_ff @(posedge clk) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      go         = 1'b0;
      start_scan = 1'b0;
      case (state)
         ST_IDLE: if (start && ch_mask != 8'd0) begin
            start_scan = 1'b1;
            go         = 1'b1;
            state_nx   = ST_CONV;
         end
         ST_CONV:  if (conv_end)  state_nx = ST_SHIFT;
         ST_SHIFT: if (frame_end) state_nx = ST_GAP;
         ST_GAP: if (gap_end) begin
            if (!scan_over) begin
               if (sample.sample_valid) begin
                  state_nx = ST_HOLD;
               end else begin
                  go       = 1'b1;
                  state_nx = ST_CONV;
               end
            end else if (continuous && ch_mask != 8'd0) begin
               start_scan = 1'b1;
               go         = 1'b1;
               state_nx   = ST_CONV;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_HOLD: if (!sample.sample_valid) begin
            go       = 1'b1;
            state_nx = ST_CONV;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Each frame shifts the config for the next conversion; once the mask is exhausted
   // a dummy config (first channel) is sent so the final channel's result can be read.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         gap_cnt             <= '0;
         uni_q               <= 1'b0;
         first_ch            <= '0;
         cfg_ch              <= '0;
         conv_ch             <= '0;
         cfg_left            <= '0;
         conv_valid          <= 1'b0;
         dummy               <= 1'b0;
         scan_over           <= 1'b0;
         sample.sample_data  <= '0;
         sample.sample_ch    <= '0;
         sample.sample_last  <= 1'b0;
         sample.sample_valid <= 1'b0;
         scan_done_irq       <= 1'b0;
      end else begin
         gap_cnt <= (state == ST_GAP && !gap_end) ? gap_cnt + 1'b1 : '0;
         if (start_scan) begin
            uni_q      <= uni;
            first_ch   <= lowest_ch(ch_mask);
            cfg_ch     <= lowest_ch(ch_mask);
            cfg_left   <= ch_mask & ~(8'd1 << lowest_ch(ch_mask));
            conv_valid <= 1'b0;
            dummy      <= 1'b0;
            scan_over  <= 1'b0;
         end else if (frame_end) begin
            conv_ch    <= cfg_ch;
            conv_valid <= 1'b1;
            scan_over  <= conv_valid && dummy;
            if (cfg_left != 8'd0) begin
               cfg_ch   <= lowest_ch(cfg_left);
               cfg_left <= cfg_left & ~(8'd1 << lowest_ch(cfg_left));
               dummy    <= 1'b0;
            end else begin
               cfg_ch <= first_ch;
               dummy  <= 1'b1;
            end
         end
         if (load) begin
            sample.sample_data  <= result;
            sample.sample_ch    <= conv_ch;
            sample.sample_last  <= dummy;
            sample.sample_valid <= 1'b1;
         end else if (sample.sample_valid && sample.sample_ready) begin
            sample.sample_valid <= 1'b0;
         end
         if (load && dummy)  scan_done_irq <= 1'b1;
         else if (irq_clear) scan_done_irq <= 1'b0;
      end
   end
endmodule

// File: tb/tb_adc_ltc2308_scan.sv
// tb/tb_adc_ltc2308_scan.sv - randomized self-checking bench with LTC2308 model and sample scoreboard
module tb_adc_ltc2308_scan;
   localparam int SCK_HALF  = 2;
   localparam int TCONV_CYC = 80;
   localparam int CONVST_W  = 2;
   localparam int GAP_CYC   = 4;
   localparam int FRAME     = TCONV_CYC + 24 * SCK_HALF + GAP_CYC;

   logic       clk = 1'b0, reset_n = 1'b0, start = 1'b0, continuous = 1'b0, uni = 1'b0;
   logic       irq_clear = 1'b0, adc_sdo = 1'b0;
   logic [7:0] ch_mask = 8'd0;
   logic       scan_done_irq, busy, adc_convst, adc_sck, adc_sdi;

   adc_ltc2308_scan_if sif();

   adc_ltc2308_scan #(
      .SCK_HALF(SCK_HALF), .TCONV_CYC(TCONV_CYC), .CONVST_W(CONVST_W), .GAP_CYC(GAP_CYC)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .continuous(continuous),
      .ch_mask(ch_mask), .uni(uni), .sample(sif), .scan_done_irq(scan_done_irq),
      .irq_clear(irq_clear), .busy(busy), .adc_convst(adc_convst), .adc_sck(adc_sck),
      .adc_sdi(adc_sdi), .adc_sdo(adc_sdo)
   );

   always #10 clk = ~clk;

   int n_cmp = 0, n_err = 0;
   int convst_rises = 0, sck_rises = 0, busy_cycles = 0, cw = 0;
   logic convst_d = 1'b0, sck_d = 1'b0, rand_rdy = 1'b0;
   logic [11:0] adc_val [8];
   logic [15:0] exp_q [$];
   logic [5:0]  cfg_exp [$];
   logic [5:0]  cfg_seen [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [5:0] cfgw(input logic [2:0] c, input logic u);
      return {1'b1, c[0], c[2], c[1], u, 1'b0};
   endfunction

   // LTC2308 model: converts with the last complete config, shifts MSB first, changes sdo on sck fall
   logic [5:0]  last_cfg = 6'd0, sh_in = 6'd0;
   logic        have_cfg = 1'b0;
   int          sck_n = 0;
   logic [11:0] out_w = 12'd0;

   always @(posedge adc_convst) begin
      out_w   = have_cfg ? adc_val[{last_cfg[3], last_cfg[2], last_cfg[4]}] : 12'($urandom);
      sck_n   = 0;
      adc_sdo = out_w[11];
   end

   always @(posedge adc_sck) begin
      if (sck_n < 6) sh_in = {sh_in[4:0], adc_sdi};
      sck_n++;
      if (sck_n == 12) begin
         last_cfg = sh_in;
         have_cfg = 1'b1;
         cfg_seen.push_back(sh_in);
      end
   end

   always @(negedge adc_sck) if (sck_n > 0 && sck_n < 12) adc_sdo = out_w[11 - sck_n];

   always @(negedge clk) begin
      if (adc_convst && !convst_d) convst_rises++;
      if (adc_sck && !sck_d) sck_rises++;
      if (busy === 1'b1) busy_cycles++;
      if (adc_convst) cw++;
      else if (cw > 0) begin
         chk("convst_width", cw, CONVST_W);
         cw = 0;
      end
      convst_d = adc_convst;
      sck_d    = adc_sck;
      if (sif.sample_valid === 1'b1 && sif.sample_ready === 1'b1) begin
         if (exp_q.size() == 0) chk("extra_sample", {sif.sample_last, sif.sample_ch, sif.sample_data}, 32'hFFFF_FFFF);
         else chk("sample", {sif.sample_last, sif.sample_ch, sif.sample_data}, exp_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_rdy) sif.sample_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic expect_scan(input logic [7:0] m, input logic u);
      logic [2:0] chs [$];
      for (int i = 0; i < 8; i++) if (m[i]) chs.push_back(3'(i));
      for (int i = 0; i < chs.size(); i++) begin
         exp_q.push_back({1'(i == chs.size() - 1), chs[i], adc_val[chs[i]]});
         cfg_exp.push_back(cfgw(chs[i], u));
      end
      cfg_exp.push_back(cfgw(chs[0], u));
   endtask

   task automatic do_start(input logic [7:0] m, input logic u, input logic cont);
      ch_mask    = m;
      uni        = u;
      continuous = cont;
      start      = 1'b1;
      tick();
      start = 1'b0;
      if (m != 8'd0) expect_scan(m, u);
   endtask

   task automatic wait_done(input int budget);
      int c = 0;
      while ((busy || sif.sample_valid || exp_q.size() != 0) && c < budget) begin
         tick();
         c++;
      end
      chk("wait_done_timeout", 32'(c >= budget), 0);
   endtask

   task automatic wait_q(input int n, input int budget);
      int c = 0;
      while (exp_q.size() > n && c < budget) begin
         tick();
         c++;
      end
      chk("wait_sample_timeout", 32'(c >= budget), 0);
   endtask

   task automatic check_cfgs();
      chk("cfg_count", cfg_seen.size(), cfg_exp.size());
      for (int i = 0; i < cfg_seen.size() && i < cfg_exp.size(); i++) chk("cfg_word", cfg_seen[i], cfg_exp[i]);
      cfg_seen.delete();
      cfg_exp.delete();
   endtask

   task automatic check_zero();
      chk("rst_pins", {adc_convst, adc_sck, adc_sdi}, 0);
      chk("rst_busy_irq", {busy, scan_done_irq}, 0);
      chk("rst_sample", {sif.sample_valid, sif.sample_last, sif.sample_ch, sif.sample_data}, 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int snap_c, snap_s;
      sif.sample_ready = 1'b1;
      for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom);
      adc_val[0] = 12'hA5A;
      adc_val[2] = 12'h3C3;
      tick();
      tick();
      check_zero();
      reset_n = 1'b1;
      tick();

      // 1: mask 05, unipolar, with an ignored start mid-scan
      busy_cycles = 0; convst_rises = 0; sck_rises = 0;
      do_start(8'h05, 1'b1, 1'b0);
      repeat (150) tick();
      ch_mask = 8'hFF;
      start   = 1'b1;
      tick();
      start = 1'b0;
      wait_done(2000);
      chk("s1_busy_cycles", busy_cycles, 3 * FRAME);
      chk("s1_convst_count", convst_rises, 3);
      chk("s1_sck_count", sck_rises, 36);
      chk("s1_irq", scan_done_irq, 1);
      if (cfg_seen.size() >= 3) begin
         chk("s1_cfg0", cfg_seen[0], 6'b100010);
         chk("s1_cfg1", cfg_seen[1], 6'b100110);
         chk("s1_cfg2", cfg_seen[2], 6'b100010);
      end
      check_cfgs();
      irq_clear = 1'b1;
      tick();
      irq_clear = 1'b0;

      // 2: full mask, downstream stalls after the first sample
      for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom);
      do_start(8'hFF, 1'($urandom_range(0, 1)), 1'b0);
      wait_q(7, 2000);
      sif.sample_ready = 1'b0;
      repeat (400) tick();
      snap_c = convst_rises;
      snap_s = sck_rises;
      repeat (200) tick();
      chk("s2_hold_convst", convst_rises, snap_c);
      chk("s2_hold_sck", sck_rises, snap_s);
      chk("s2_hold_busy_valid", {busy, sif.sample_valid}, 2'b11);
      rand_rdy = 1'b1;
      wait_done(8000);
      rand_rdy = 1'b0;
      sif.sample_ready = 1'b1;
      chk("s2_all_samples", exp_q.size(), 0);
      check_cfgs();
      irq_clear = 1'b1;
      tick();
      irq_clear = 1'b0;

      // 3: continuous single-channel scans, continuous dropped during the third
      convst_rises = 0;
      do_start(8'h80, 1'b0, 1'b1);
      expect_scan(8'h80, 1'b0);
      expect_scan(8'h80, 1'b0);
      for (int k = 0; k < 3; k++) begin
         wait_q(2 - k, 3 * FRAME);
         chk("s3_irq_set", scan_done_irq, 1);
         irq_clear = 1'b1;
         tick();
         irq_clear = 1'b0;
         chk("s3_irq_clr", scan_done_irq, 0);
         if (k == 1) begin
            repeat (100) tick();
            continuous = 1'b0;
         end
      end
      wait_done(1000);
      chk("s3_convst_count", convst_rises, 6);
      check_cfgs();

      // 4: empty mask does nothing
      convst_rises = 0; sck_rises = 0; busy_cycles = 0;
      do_start(8'h00, 1'b1, 1'b0);
      repeat (30) tick();
      chk("s4_quiet", {convst_rises[15:0], sck_rises[15:0]}, 0);
      chk("s4_busy_irq", {busy_cycles[30:0], scan_done_irq}, 0);

      // 5: irq_clear coincident with the final load loses to the set
      sif.sample_ready = 1'b0;
      do_start(8'h10, 1'($urandom_range(0, 1)), 1'b0);
      repeat (2 * FRAME - GAP_CYC - 1) tick();
      chk("s5_pre_valid", sif.sample_valid, 0);
      irq_clear = 1'b1;
      tick();
      irq_clear = 1'b0;
      chk("s5_set_wins", {sif.sample_valid, scan_done_irq}, 2'b11);
      irq_clear = 1'b1;
      tick();
      irq_clear = 1'b0;
      chk("s5_cleared", scan_done_irq, 0);
      sif.sample_ready = 1'b1;
      wait_done(1000);
      check_cfgs();

      // 6: pending sample survives IDLE, then reset mid-SHIFT clears everything
      sif.sample_ready = 1'b0;
      do_start(8'h01, 1'b1, 1'b0);
      repeat (2 * FRAME) tick();
      chk("s6_idle_pending", {busy, sif.sample_valid, scan_done_irq}, 3'b011);
      do_start(8'h01, 1'b1, 1'b0);
      repeat (TCONV_CYC + 12 * SCK_HALF) tick();
      chk("s6_in_shift", busy, 1);
      reset_n = 1'b0;
      tick();
      check_zero();
      reset_n = 1'b1;
      exp_q.delete();
      cfg_exp.delete();
      cfg_seen.delete();
      sif.sample_ready = 1'b1;
      do_start(8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)), 1'b0);
      wait_done(4000);
      check_cfgs();

      // random scans with random backpressure
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom);
         rand_rdy = 1'b1;
         do_start(8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)), 1'b0);
         wait_done(12000);
         chk("rand_irq", scan_done_irq, 1);
         check_cfgs();
         irq_clear = 1'b1;
         tick();
         irq_clear = 1'b0;
      end
      rand_rdy = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
